// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with a registered one-hot grant, optional grant-hold
// mode and a bounded hold timer so a holder cannot starve waiting requesters.
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int HOLD     = 0,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // With MAX_HOLD=0 the counter only needs to record "held at least once".
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? HW'(1) : HW'(MAX_HOLD);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_arbiter_n: N must be in 2..16");
    end
    if (HOLD != 0 && HOLD != 1) begin : g_bad_hold
        $error("rr_arbiter_n: HOLD must be 0 or 1");
    end
    if (HOLD == 1 && (MAX_HOLD < 0 || MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("rr_arbiter_n: MAX_HOLD must be in 0..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Handshake: req is level-sensitive and sampled only at rising edges; a
    // requester owns the resource in every cycle its grant bit is high.
    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

    logic [N-1:0]    others;
    logic [N-1:0]    mask;
    logic            rel_a;
    logic            rel_b;
    logic            keep;
    logic            found;
    logic [IW-1:0]   win;

    // While granted, the owner is always last_q, so every search starts at last_q+1.
    always_comb begin
        others = req & ~grant_q;
        rel_a  = ~|(req & grant_q);
        rel_b  = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD)) && (|others);
        keep   = (HOLD != 0) && (state_q == GRANT) && !rel_a && !rel_b;
        mask   = ((HOLD != 0) && (state_q == GRANT) && rel_b) ? others : req;
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && mask[(int'(last_q) + 1 + k) % N]) begin
                found = 1'b1;
                win   = IW'((int'(last_q) + 1 + k) % N);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = GRANT;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    last_d       = win;
                    hold_cnt_d   = HW'(1);
                end
            end
            GRANT: begin
                if (keep) begin
                    if (hold_cnt_q != HOLD_SAT) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    last_d       = win;
                    hold_cnt_d   = HW'(1);
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= IW'(N - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == GRANT);
    assign grant_idx   = (state_q == GRANT) ? last_q : '0;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: three instances cover HOLD=0, HOLD=1 with a
// bounded hold, and HOLD=1 with unlimited hold.
module tb_rr_arbiter_n;

    logic       clk;
    logic       rst;
    logic [3:0] req0, req1, req2;
    logic [3:0] g0, g1, g2;
    logic [1:0] gi0, gi1, gi2;
    logic       gv0, gv1, gv2;

    int checks = 0;
    int errors = 0;

    rr_arbiter_n #(.N(4), .HOLD(0), .MAX_HOLD(4)) u0 (
        .clk(clk), .rst(rst), .req(req0),
        .grant(g0), .grant_idx(gi0), .grant_valid(gv0)
    );
    rr_arbiter_n #(.N(4), .HOLD(1), .MAX_HOLD(3)) u1 (
        .clk(clk), .rst(rst), .req(req1),
        .grant(g1), .grant_idx(gi1), .grant_valid(gv1)
    );
    rr_arbiter_n #(.N(4), .HOLD(1), .MAX_HOLD(0)) u2 (
        .clk(clk), .rst(rst), .req(req2),
        .grant(g2), .grant_idx(gi2), .grant_valid(gv2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [1:0] exp_idx(input logic [3:0] eg);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (eg[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [3:0] g, input logic [1:0] gi,
                         input logic gv, input logic [3:0] eg);
        logic [1:0] ei;
        logic       ev;
        ei = exp_idx(eg);
        ev = |eg;
        checks++;
        assert ({g, gi, gv} === {eg, ei, ev})
        else begin
            errors++;
            $error("FAIL %s: grant=%b idx=%0d valid=%b, expected grant=%b idx=%0d valid=%b",
                   tag, g, gi, gv, eg, ei, ev);
        end
    endtask

    task automatic c0(input string tag, input logic [3:0] eg);
        check(tag, g0, gi0, gv0, eg);
    endtask
    task automatic c1(input string tag, input logic [3:0] eg);
        check(tag, g1, gi1, gv1, eg);
    endtask
    task automatic c2(input string tag, input logic [3:0] eg);
        check(tag, g2, gi2, gv2, eg);
    endtask

    initial begin
        rst  = 1'b0;
        req0 = 4'b0000;
        req1 = 4'b0000;
        req2 = 4'b0000;
        step();
        step();
        c0("reset_u0", 4'b0000);
        c1("reset_u1", 4'b0000);
        c2("reset_u2", 4'b0000);

        // HOLD=0 rotation with all requesting; requester 0 first after reset
        rst  = 1'b1;
        req0 = 4'b1111;
        step(); c0("rot_0", 4'b0001);
        step(); c0("rot_1", 4'b0010);
        step(); c0("rot_2", 4'b0100);
        step(); c0("rot_3", 4'b1000);
        step(); c0("rot_4", 4'b0001);
        step(); c0("rot_5", 4'b0010);

        // asynchronous reset mid-grant, away from any clock edge
        #2 rst = 1'b0;
        #1 c0("async_rst", 4'b0000);
        step();
        rst = 1'b1;
        step(); c0("post_rst_first", 4'b0001);

        // HOLD=0 sparse requests
        req0 = 4'b1010;
        step(); c0("sparse_a0", 4'b0010);
        step(); c0("sparse_a1", 4'b1000);
        step(); c0("sparse_a2", 4'b0010);
        step(); c0("sparse_a3", 4'b1000);
        req0 = 4'b0010;
        step(); c0("single_0", 4'b0010);
        step(); c0("single_1", 4'b0010);
        req0 = 4'b0000;
        step(); c0("to_idle", 4'b0000);
        step(); c0("stay_idle", 4'b0000);
        req0 = 4'b0011;
        step(); c0("wrap_from_2", 4'b0001);
        step(); c0("wrap_next", 4'b0010);
        req0 = 4'b0000;

        // HOLD=1, MAX_HOLD=3, two competitors
        req1 = 4'b0101;
        step(); c1("hold_a0", 4'b0001);
        step(); c1("hold_a1", 4'b0001);
        step(); c1("hold_a2", 4'b0001);
        step(); c1("hold_b0", 4'b0100);
        step(); c1("hold_b1", 4'b0100);
        step(); c1("hold_b2", 4'b0100);
        step(); c1("hold_a_again", 4'b0001);

        // single requester holds indefinitely (count saturates)
        req1 = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step(); c1($sformatf("solo_%0d", i), 4'b0001);
        end
        req1 = 4'b1000;
        step(); c1("drop_move", 4'b1000);
        req1 = 4'b1001;
        step(); c1("limit_k0", 4'b1000);
        step(); c1("limit_k1", 4'b1000);
        step(); c1("limit_wrap", 4'b0001);
        req1 = 4'b0000;
        step(); c1("hold_idle", 4'b0000);

        // HOLD=1, MAX_HOLD=0: unlimited hold until owner drops
        req2 = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            step(); c2($sformatf("unl_%0d", i), 4'b0001);
        end
        req2 = 4'b0010;
        step(); c2("unl_release", 4'b0010);
        req2 = 4'b0000;
        step(); c2("unl_idle", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised N-way round-robin arbiter with registered one-hot grant, optional grant-hold mode and a bounded hold timer for fairness. It is the general successor to the two-requester arbiter FSM and sits between N request sources and one shared resource such as a bus port or memory slave. Grants rotate starting from the requester after the last one served, so no requester is starved.

## Interface
- N, default 4: number of requesters, legal range 2..16.
- HOLD, default 0: 0 re-arbitrates every cycle; 1 keeps the grant while the holder's req stays high.
- MAX_HOLD, default 4: HOLD=1 only, the maximum consecutive grant cycles when another requester is waiting; 0 means unlimited; legal range 0..255.

- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; one clock; asserting rst low immediately forces all state to reset values.
- req  input  N  request vector; bit i high means requester i wants the resource.
- grant  output  N  registered one-hot grant; all zero when nothing is granted.
- grant_idx  output  $clog2(N)  binary index of the granted requester; 0 when grant_valid=0.
- grant_valid  output  1  high when grant is non-zero.

## Operation
- **State machine** (2 states):
  - IDLE: no grant.
  - GRANT: grant held by `owner`.
- **Internal registers:**
  - `last`: index of the most recent grantee. Reset value is N-1, so requester 0 has first priority.
  - `hold_cnt`: width $clog2(MAX_HOLD+1), saturating.
- **Priority order:** search starts at index (last+1) mod N and wraps upward; the winner is the first set bit of req in that order.
- **IDLE:**
  - If any req bit is set, the winner w is granted at the next edge: state=GRANT, grant=1<<w, last=w, hold_cnt=1.
  - Otherwise stay in IDLE.
- **GRANT, HOLD=0:**
  - Re-arbitrate every edge using the priority order.
  - When the owner is the only requester it wins again and keeps the grant.
  - When req=0 the block returns to IDLE.
- **GRANT, HOLD=1:** keep the grant unless one of these conditions holds:
  - (a) req[owner]=0, or
  - (b) MAX_HOLD!=0, hold_cnt==MAX_HOLD, and some other req bit is set.
- **Releasing the grant (HOLD=1):** on (a) or (b), re-arbitrate at the same edge.
  - The winner is searched from owner+1.
  - Under (b) the owner is excluded from this search.
  - If no eligible requester exists, the block goes to IDLE.
  - There is no idle bubble between consecutive grants.
- **hold_cnt updates:**
  - On keep, hold_cnt increments and saturates at MAX_HOLD.
  - On any new grant, including a re-grant to the same owner under HOLD=0, hold_cnt=1.
  - With HOLD=0, hold_cnt is unused.
- **Pointer retention:** `last` keeps its value through IDLE; rotation resumes from the previous grantee.
- **Output invariants:**
  - grant is always one-hot or zero.
  - grant_idx and grant_valid are always consistent with grant.
- **Illegal parameters:** N<2 and HOLD=1 with MAX_HOLD>255 fail elaboration.

## Timing
- Latency: the grant appears on the first rising edge after req is sampled high (1 cycle).
- Release: dropping req[owner] removes or moves the grant at the next edge.
- Reset values: grant=0, grant_idx=0, grant_valid=0, state=IDLE, last=N-1, hold_cnt=0.
- Reset assertion mid-grant clears all outputs asynchronously, without waiting for a clock.
- First arbitration after reset release: on the first edge with rst high, requester 0 wins if requesting.
- Simultaneous owner drop and new requests: the new winner is granted at the same edge.
- Requests that go high and low between edges are not seen; req is sampled only at clock edges.
- Wrap-around: after index N-1 the search continues at 0.

## Test plan
- **Reset:** rst=0 mid-grant with req=4'b1111 -> grant=0, grant_valid=0 immediately. Release rst -> first grant is 4'b0001.
- **HOLD=0, N=4, req held at 4'b1111 for 6 cycles** -> grant sequence 0001, 0010, 0100, 1000, 0001, 0010; grant_idx 0,1,2,3,0,1.
- **HOLD=0, sparse requests:** req=4'b1010 -> grants alternate 0010, 1000. Drop to req=4'b0010 -> 0010 every cycle. req=0 -> IDLE. Then req=4'b0011 -> grant 0001 (search starts at last+1=2 and wraps to 0).
- **HOLD=1, MAX_HOLD=3, req=4'b0101 continuously** -> 0001 for 3 cycles, then 0100 for 3 cycles, then 0001, with no gap cycles.
- **HOLD=1, MAX_HOLD=3, req=4'b0001 only** -> grant stays 0001 indefinitely (no competitor). Then req[0] drops while req[3] rises -> grant 1000 at the next edge.
- **HOLD=1, MAX_HOLD=0, req=4'b0011** -> 0001 held until req[0] drops, then 0010 at the next edge.
